// File: rtl/cpun_pkg.sv
// Shared constants for the cpun multi-cycle core: opcodes, ALU function
// codes and the sequencer state encoding.
package cpun_pkg;

   // Major opcodes, IR[15:12]
   localparam logic [3:0] OP_ALU  = 4'b0000;
   localparam logic [3:0] OP_LI   = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_BEQZ = 4'b0100;
   localparam logic [3:0] OP_HALT = 4'b1111;

   // ALU function codes, IR[7:4] when op == OP_ALU
   localparam logic [3:0] F_ADD = 4'b1010;
   localparam logic [3:0] F_SUB = 4'b0010;
   localparam logic [3:0] F_AND = 4'b1100;
   localparam logic [3:0] F_OR  = 4'b1110;

   // Sequencer states
   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] EXEC  = 2'd1;
   localparam logic [1:0] MEM   = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   // True for the four function codes the ALU group implements.
   function automatic logic is_alu_fn(input logic [3:0] fn);
      return (fn == F_ADD) || (fn == F_SUB) || (fn == F_AND) || (fn == F_OR);
   endfunction

endpackage

// File: rtl/cpun_regfile.sv
// Register file: NREG x DW, one synchronous write port, two combinational
// read ports, all entries cleared by synchronous reset.
module cpun_regfile #(
   parameter int DW   = 16,
   parameter int NREG = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    we_i,
   input  logic [$clog2(NREG)-1:0] waddr_i,
   input  logic [DW-1:0]           wdata_i,
   input  logic [$clog2(NREG)-1:0] raddr_a_i,
   output logic [DW-1:0]           rdata_a_o,
   input  logic [$clog2(NREG)-1:0] raddr_b_i,
   output logic [DW-1:0]           rdata_b_o
);

   logic [DW-1:0] regs_q [NREG];

   // Write port; reset clears every register.
   // NOTE: this array is reset because the core's programs rely on all registers
   // reading zero after reset; that forces flops rather than a RAM macro.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = regs_q[raddr_a_i];
   assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/cpun_multicycle.sv
// cpun multi-cycle core: FETCH/EXEC/MEM/STOP sequencer around a shared
// register file and an inline ALU, with a handshaked data port.
module cpun_multicycle #(
   parameter int            DW       = 16,
   parameter int            NREG     = 16,
   parameter int            AW       = 16,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          CK,
   input  logic          RST,
   output logic [AW-1:0] IADDR,
   input  logic [15:0]   IDATA,
   output logic          DREQ,
   output logic          DWE,
   output logic [AW-1:0] DADDR,
   output logic [DW-1:0] DWDATA,
   input  logic [DW-1:0] DRDATA,
   input  logic          DACK,
   output logic          RETIRE,
   output logic          HALTED,
   output logic          ERR
);

   import cpun_pkg::*;

   localparam int IW = $clog2(NREG);

   logic [1:0]    state_q,  state_d;
   logic [AW-1:0] pc_q,     pc_d;
   logic [15:0]   ir_q,     ir_d;
   logic          dreq_q,   dreq_d;
   logic          dwe_q,    dwe_d;
   logic [AW-1:0] daddr_q,  daddr_d;
   logic [DW-1:0] dwdata_q, dwdata_d;
   logic          retire_q, retire_d;
   logic          halted_q, halted_d;
   logic          err_q,    err_d;

   // Instruction fields; register indices use the low IW bits of each field.
   logic [3:0]    op, fn, fld_d, fld_s;
   logic [IW-1:0] rd_idx, rs_idx;
   logic [DW-1:0] rd_val, rs_val, alu_res, li_val;
   logic [AW-1:0] br_off;

   assign op     = ir_q[15:12];
   assign fld_d  = ir_q[11:8];
   assign fn     = ir_q[7:4];
   assign fld_s  = ir_q[3:0];
   assign rd_idx = fld_d[IW-1:0];
   assign rs_idx = fld_s[IW-1:0];
   assign li_val = {{(DW-8){ir_q[7]}}, ir_q[7:0]};
   assign br_off = {{(AW-9){ir_q[7]}}, ir_q[7:0], 1'b0};

   logic          rf_we;
   logic [DW-1:0] rf_wdata;

   cpun_regfile #(
      .DW   (DW),
      .NREG (NREG)
   ) u_regfile (
      .clk_i     (CK),
      .rst_i     (RST),
      .we_i      (rf_we),
      .waddr_i   (rd_idx),
      .wdata_i   (rf_wdata),
      .raddr_a_i (rd_idx),
      .rdata_a_o (rd_val),
      .raddr_b_i (rs_idx),
      .rdata_b_o (rs_val)
   );

   // ALU: register-register group, modulo 2^DW, no flags.
   always_comb begin
      alu_res = '0;
      case (fn)
         F_ADD:   alu_res = rd_val + rs_val;
         F_SUB:   alu_res = rd_val + ~rs_val + DW'(1);
         F_AND:   alu_res = rd_val & rs_val;
         F_OR:    alu_res = rd_val | rs_val;
         default: alu_res = '0;
      endcase
   end

   // Sequencer: next state, PC, data-port request and register write control.
   // NOTE: every output of this block is given its hold/default value first, so
   // no path through the case leaves a variable unassigned and no latch appears.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      dreq_d   = dreq_q;
      dwe_d    = dwe_q;
      daddr_d  = daddr_q;
      dwdata_d = dwdata_q;
      retire_d = 1'b0;
      halted_d = halted_q;
      err_d    = err_q;
      rf_we    = 1'b0;
      rf_wdata = alu_res;

      case (state_q)
         FETCH: begin
            ir_d    = IDATA;
            pc_d    = pc_q + AW'(2);
            state_d = EXEC;
         end
         EXEC: begin
            case (op)
               OP_ALU: begin
                  if (is_alu_fn(fn)) begin
                     rf_we    = 1'b1;
                     rf_wdata = alu_res;
                     retire_d = 1'b1;
                     state_d  = FETCH;
                  end else begin
                     halted_d = 1'b1;
                     err_d    = 1'b1;
                     state_d  = STOP;
                  end
               end
               OP_LI: begin
                  rf_we    = 1'b1;
                  rf_wdata = li_val;
                  retire_d = 1'b1;
                  state_d  = FETCH;
               end
               OP_BEQZ: begin
                  // pc_q already points past this instruction.
                  if (rd_val == '0) pc_d = pc_q + br_off;
                  retire_d = 1'b1;
                  state_d  = FETCH;
               end
               OP_LD, OP_ST: begin
                  // Address is captured here, so Rd == Rs loads use the old Rs.
                  dreq_d   = 1'b1;
                  dwe_d    = (op == OP_ST);
                  daddr_d  = AW'(rs_val);
                  dwdata_d = rd_val;
                  state_d  = MEM;
               end
               OP_HALT: begin
                  halted_d = 1'b1;
                  state_d  = STOP;
               end
               default: begin
                  halted_d = 1'b1;
                  err_d    = 1'b1;
                  state_d  = STOP;
               end
            endcase
         end
         MEM: begin
            if (DACK) begin
               dreq_d   = 1'b0;
               retire_d = 1'b1;
               state_d  = FETCH;
               if (!dwe_q) begin
                  rf_we    = 1'b1;
                  rf_wdata = DRDATA;
               end
            end
         end
         default: begin
            // STOP is absorbing until reset.
            state_d = STOP;
         end
      endcase
   end

   // State registers; synchronous reset restores every architectural value.
   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from values sampled before the edge.
   always_ff @(posedge CK) begin
      if (RST) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         dreq_q   <= 1'b0;
         dwe_q    <= 1'b0;
         daddr_q  <= '0;
         dwdata_q <= '0;
         retire_q <= 1'b0;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         dreq_q   <= dreq_d;
         dwe_q    <= dwe_d;
         daddr_q  <= daddr_d;
         dwdata_q <= dwdata_d;
         retire_q <= retire_d;
         halted_q <= halted_d;
         err_q    <= err_d;
      end
   end

   assign IADDR  = pc_q;
   assign DREQ   = dreq_q;
   assign DWE    = dwe_q;
   assign DADDR  = daddr_q;
   assign DWDATA = dwdata_q;
   assign RETIRE = retire_q;
   assign HALTED = halted_q;
   assign ERR    = err_q;

endmodule

// File: tb/tb_cpun_multicycle.sv
// Scoreboard bench for cpun_multicycle: programs are interpreted by an
// instruction-level model that queues expected retirements and data-port
// transactions; a negedge monitor compares them with what the core presents.
module tb_cpun_multicycle;

   localparam int            DW       = 32;
   localparam int            NREG     = 16;
   localparam int            AW       = 16;
   localparam logic [15:0]   RESET_PC = 16'h0000;

   logic          CK = 1'b0;
   logic          RST;
   logic [AW-1:0] IADDR;
   logic [15:0]   IDATA;
   logic          DREQ, DWE;
   logic [AW-1:0] DADDR;
   logic [DW-1:0] DWDATA, DRDATA;
   logic          DACK;
   logic          RETIRE, HALTED, ERR;

   cpun_multicycle #(
      .DW       (DW),
      .NREG     (NREG),
      .AW       (AW),
      .RESET_PC (RESET_PC)
   ) dut (
      .CK     (CK),
      .RST    (RST),
      .IADDR  (IADDR),
      .IDATA  (IDATA),
      .DREQ   (DREQ),
      .DWE    (DWE),
      .DADDR  (DADDR),
      .DWDATA (DWDATA),
      .DRDATA (DRDATA),
      .DACK   (DACK),
      .RETIRE (RETIRE),
      .HALTED (HALTED),
      .ERR    (ERR)
   );

   always #5 CK = ~CK;

   typedef struct packed {logic we; logic [15:0] addr; logic [31:0] data;} mem_t;
   typedef struct packed {logic [15:0] pc; logic [31:0] gap;} ret_t;

   logic [15:0]   rom  [32768];
   logic [DW-1:0] dmem [65536];   // slave contents
   logic [DW-1:0] mmem [65536];   // model's view of memory
   assign IDATA = rom[IADDR[15:1]];

   mem_t mem_q[$];
   ret_t ret_q[$];
   int   waits_q[$];
   int   force_w = -1;
   int   wp;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- instruction encoders ----------------
   function automatic logic [15:0] enc_alu(input logic [3:0] f, input logic [3:0] d, input logic [3:0] s);
      return {4'h0, d, f, s};
   endfunction
   function automatic logic [15:0] enc_li(input logic [3:0] d, input logic [7:0] imm);
      return {4'h1, d, imm};
   endfunction
   function automatic logic [15:0] enc_ld(input logic [3:0] d, input logic [3:0] s);
      return {4'h2, d, 4'h0, s};
   endfunction
   function automatic logic [15:0] enc_st(input logic [3:0] d, input logic [3:0] s);
      return {4'h3, d, 4'h0, s};
   endfunction
   function automatic logic [15:0] enc_beqz(input logic [3:0] d, input logic [7:0] imm);
      return {4'h4, d, imm};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 32768; i++) rom[i] = 16'hF000;
      wp = 0;
   endtask
   task automatic emit(input logic [15:0] w);
      rom[wp] = w;
      wp++;
   endtask
   // Store every register to 0x40+i so its value reaches the scoreboard.
   task automatic emit_dump();
      for (int i = 0; i < 15; i++) begin
         emit(enc_li(4'd15, 8'(8'h40 + i)));
         emit(enc_st(4'(i), 4'd15));
      end
      emit(enc_st(4'd15, 4'd15));
      emit(16'hF000);
   endtask

   // ---------------- reference model ----------------
   // Interprets the ROM from RESET_PC; records what the core must do.
   task automatic model_run(output logic [15:0] fin_pc, output logic fin_err);
      logic [DW-1:0] r [16];
      logic [15:0]   pc, npc, w, addr;
      logic [3:0]    op, d, f, s;
      logic [7:0]    imm;
      int            gap, wt;
      bit            stop;
      for (int i = 0; i < 16; i++) r[i] = '0;
      pc = RESET_PC; fin_err = 1'b0; fin_pc = pc; stop = 0;
      for (int step = 0; step < 4000 && !stop; step++) begin
         w   = rom[pc[15:1]];
         npc = pc + 16'd2;
         op = w[15:12]; d = w[11:8]; f = w[7:4]; s = w[3:0]; imm = w[7:0];
         gap = 2;
         case (op)
            4'h0: begin
               if      (f == 4'b1010) r[d] = r[d] + r[s];
               else if (f == 4'b0010) r[d] = r[d] - r[s];
               else if (f == 4'b1100) r[d] = r[d] & r[s];
               else if (f == 4'b1110) r[d] = r[d] | r[s];
               else begin fin_err = 1'b1; stop = 1; end
            end
            4'h1: r[d] = 32'(int'($signed(imm)));
            4'h2, 4'h3: begin
               addr = r[s][15:0];
               wt = (force_w >= 0) ? force_w : int'($urandom_range(0, 3));
               waits_q.push_back(wt);
               gap = 3 + wt;
               if (op == 4'h2) begin
                  mem_q.push_back('{1'b0, addr, 32'h0});
                  r[d] = mmem[addr];
               end else begin
                  mem_q.push_back('{1'b1, addr, r[d]});
                  mmem[addr] = r[d];
               end
            end
            4'h4: if (r[d] == 0) npc = 16'(int'(pc) + 2 + 2 * int'($signed(imm)));
            4'hF: stop = 1;
            default: begin fin_err = 1'b1; stop = 1; end
         endcase
         if (!stop) ret_q.push_back('{npc, 32'(gap)});
         pc = npc;
      end
      fin_pc = pc;
   endtask

   // ---------------- data slave ----------------
   int sl_w;
   initial begin
      DACK = 1'b0;
      DRDATA = '0;
      forever begin
         @(posedge CK); #1;
         DACK = 1'b0;
         if (DREQ && !RST) begin
            sl_w = (waits_q.size() > 0) ? waits_q.pop_front() : 0;
            repeat (sl_w) begin @(posedge CK); #1; end
            if (!DWE) DRDATA = dmem[DADDR];
            else      dmem[DADDR] = DWDATA;
            DACK = 1'b1;
         end
      end
   end

   // ---------------- monitor ----------------
   int   mon_cnt = 0;
   int   mon_last = 0;
   bit   ack_prev = 0;
   mem_t mon_m;
   ret_t mon_r;
   always @(negedge CK) begin
      mon_cnt++;
      if (RST) begin
         mon_last = mon_cnt + 1;
         ack_prev = 0;
      end else begin
         if (ack_prev) check("dreq_drop_after_ack", DREQ, 0);
         ack_prev = DREQ && DACK;
         if (RETIRE) begin
            if (ret_q.size() == 0) check("retire_unexpected", 1, 0);
            else begin
               mon_r = ret_q.pop_front();
               check("retire_next_iaddr", IADDR, mon_r.pc);
               check("retire_cycles", 32'(mon_cnt - mon_last), mon_r.gap);
            end
            mon_last = mon_cnt;
         end
         if (DREQ) begin
            if (mem_q.size() == 0) check("dreq_unexpected", 1, 0);
            else begin
               mon_m = mem_q[0];
               check("dwe", DWE, mon_m.we);
               check("daddr", DADDR, mon_m.addr);
               if (mon_m.we) check("dwdata", DWDATA, mon_m.data);
               if (DACK) void'(mem_q.pop_front());
            end
         end
      end
   end

   // ---------------- program runner ----------------
   task automatic run_prog(input string name);
      logic [15:0] fin_pc;
      logic        fin_err;
      bit          done;
      model_run(fin_pc, fin_err);
      @(posedge CK); #1 RST = 1'b0;
      done = 0;
      for (int c = 0; c < 5000 && !done; c++) begin
         @(posedge CK); #1;
         if (HALTED) done = 1;
      end
      check({name, "_halted_in_time"}, done, 1);
      repeat (3) @(posedge CK);
      #1;
      check({name, "_halted"}, HALTED, 1);
      check({name, "_err"}, ERR, fin_err);
      check({name, "_iaddr_frozen"}, IADDR, fin_pc);
      check({name, "_retires_left"}, ret_q.size(), 0);
      check({name, "_mem_left"}, mem_q.size(), 0);
      RST = 1'b1;
      repeat (2) @(posedge CK);
      #1;
      ret_q.delete(); mem_q.delete(); waits_q.delete();
   endtask

   logic [15:0] tmp_pc;
   logic        tmp_err;
   bit          seen;

   initial begin
      RST = 1'b1;
      for (int a = 0; a < 65536; a++) begin
         dmem[a] = {16'(a) ^ 16'hA5A5, 16'(a)};
         mmem[a] = dmem[a];
      end
      clear_rom();
      repeat (3) @(posedge CK);
      #1;
      check("rst_iaddr", IADDR, RESET_PC);
      check("rst_dreq", DREQ, 0);
      check("rst_dwe", DWE, 0);
      check("rst_daddr", DADDR, 0);
      check("rst_dwdata", DWDATA, 0);
      check("rst_retire", RETIRE, 0);
      check("rst_halted", HALTED, 0);
      check("rst_err", ERR, 0);

      // ALU group
      clear_rom();
      emit(enc_li(4'd1, 8'd11)); emit(enc_li(4'd3, 8'd13));
      emit(enc_li(4'd5, 8'd15)); emit(enc_li(4'd0, 8'd10));
      emit(enc_alu(4'b1010, 4'd1, 4'd3)); emit(enc_alu(4'b0010, 4'd5, 4'd0));
      emit(enc_alu(4'b1100, 4'd3, 4'd5)); emit(enc_alu(4'b1110, 4'd0, 4'd1));
      emit_dump();
      run_prog("alu");

      // Sign extension and wrap at DW = 32
      clear_rom();
      emit(enc_li(4'd2, 8'h80)); emit(enc_li(4'd8, 8'h00)); emit(enc_li(4'd9, 8'h01));
      emit(enc_alu(4'b0010, 4'd8, 4'd9));
      emit_dump();
      run_prog("li_width");

      // Load with 3 wait states, store, and a load with Rd == Rs
      clear_rom();
      dmem[16'h20] = 32'h0000BEEF; mmem[16'h20] = 32'h0000BEEF;
      force_w = 3;
      emit(enc_li(4'd4, 8'h20)); emit(enc_ld(4'd6, 4'd4));
      emit(enc_li(4'd7, 8'h12));
      for (int i = 0; i < 8; i++) emit(enc_alu(4'b1010, 4'd7, 4'd7));
      emit(enc_li(4'd11, 8'h34)); emit(enc_alu(4'b1110, 4'd7, 4'd11));
      emit(enc_st(4'd7, 4'd4)); emit(enc_ld(4'd4, 4'd4));
      emit_dump();
      run_prog("ldst");
      force_w = -1;

      // Branch backward (taken) then forward (not taken) from PC 8
      clear_rom();
      emit(enc_li(4'd0, 8'h00));      // 0
      emit(enc_beqz(4'd0, 8'h02));    // 2 -> 8
      emit(16'hF000);                 // 4 skipped
      emit(enc_li(4'd0, 8'h01));      // 6
      emit(enc_beqz(4'd0, 8'hFE));    // 8 -> 6, then 10
      emit_dump();
      run_prog("branch");

      // Illegal opcode and illegal ALU function
      clear_rom();
      emit(enc_li(4'd1, 8'd5)); emit(16'h7000);
      run_prog("illegal_op");
      clear_rom();
      emit(enc_li(4'd1, 8'd5)); emit(16'h0150);
      run_prog("illegal_fn");

      // Randomised programs with forward-only branches
      for (int p = 0; p < 8; p++) begin
         clear_rom();
         for (int i = 0; i < 16; i++) emit(enc_li(4'(i), 8'($urandom)));
         for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 8: begin
                  logic [3:0] fsel;
                  case ($urandom_range(0, 3))
                     0: fsel = 4'b1010; 1: fsel = 4'b0010;
                     2: fsel = 4'b1100; default: fsel = 4'b1110;
                  endcase
                  emit(enc_alu(fsel, 4'($urandom), 4'($urandom)));
               end
               3, 4, 9: emit(enc_li(4'($urandom), 8'($urandom)));
               5: emit(enc_ld(4'($urandom), 4'($urandom)));
               6: emit(enc_st(4'($urandom), 4'($urandom)));
               default: emit(enc_beqz(4'($urandom), 8'($urandom_range(0, 3))));
            endcase
         end
         emit_dump();
         run_prog("random");
      end

      // Reset in the middle of a load; the late DACK must be ignored
      clear_rom();
      emit(enc_li(4'd4, 8'h20)); emit(enc_ld(4'd6, 4'd4)); emit(16'hF000);
      force_w = 10;
      model_run(tmp_pc, tmp_err);
      force_w = -1;
      @(posedge CK); #1 RST = 1'b0;
      seen = 0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(posedge CK); #1;
         if (DREQ) seen = 1;
      end
      check("midmem_dreq_seen", seen, 1);
      repeat (2) begin @(posedge CK); #1; end
      RST = 1'b1;
      @(posedge CK); #1;
      check("midmem_rst_dreq", DREQ, 0);
      check("midmem_rst_iaddr", IADDR, RESET_PC);
      check("midmem_rst_retire", RETIRE, 0);
      ret_q.delete(); mem_q.delete(); waits_q.delete();
      clear_rom();
      for (int i = 0; i < 8; i++) emit(enc_alu(4'b1110, 4'(i), 4'(i)));
      emit_dump();
      run_prog("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
